caxi4interconnect_ram_fifo_rd_port: RTL

//  Read-side controller for the sync-write/async-read dual-port FIFO RAM. The write side drives wrPtr and the RAM write port.

---
 rtl/caxi4interconnect_ram_fifo_rd_port.sv | 134 +++++++++++++
 1 files changed

// File: rtl/caxi4interconnect_ram_fifo_rd_port.sv
// Read-side controller for the single-clock RAM FIFO: owns the read pointer,
// prefetches RAM words into a two-register output stage (main + skid) and
// presents them on a valid/ready stream.
module caxi4interconnect_ram_fifo_rd_port #(
  parameter  int FIFO_AWIDTH  = 9,
  parameter  int FIFO_WIDTH   = 8,
  localparam int ADDR_NC_BITS = $clog2(FIFO_WIDTH / 8)
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [FIFO_AWIDTH:0]                wrPtr,
  input  logic                                flush,
  output logic [FIFO_AWIDTH+ADDR_NC_BITS-1:0] fifoRdAddr,
  input  logic [FIFO_WIDTH-1:0]               fifoRdData,
  output logic [FIFO_AWIDTH:0]                rdPtr,
  output logic                                outValid,
  output logic [FIFO_WIDTH-1:0]               outData,
  input  logic                                outReady,
  output logic [FIFO_AWIDTH+1:0]              level,
  output logic                                empty,
  output logic                                ovfErr
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } stageState_t;

  localparam logic [FIFO_AWIDTH:0] DEPTH = {1'b1, {FIFO_AWIDTH{1'b0}}};

  stageState_t            state, nextState;
  logic [FIFO_WIDTH-1:0]  mainData, skidData;
  logic [FIFO_AWIDTH:0]   ramCnt;
  logic                   ramEmpty;
  logic                   pop, load;
  logic                   loadMain, loadSkid, skidToMain;
  logic [1:0]             stageCnt;

  assign ramCnt   = wrPtr - rdPtr;
  assign ramEmpty = (ramCnt == '0);
  assign outValid = (state != EMPTY);
  assign outData  = mainData;
  assign pop      = outValid & outReady;
  assign load     = ~ramEmpty & ((state != TWO) | pop);

  // Occupancy reporting; depends only on registered state and the writer pointer
  always_comb begin
    stageCnt = 2'd0;
    case (state)
      ONE:     stageCnt = 2'd1;
      TWO:     stageCnt = 2'd2;
      default: stageCnt = 2'd0;
    endcase
    level = {1'b0, ramCnt} + {{FIFO_AWIDTH{1'b0}}, stageCnt};
    empty = (level == '0);
  end

  // Word address from the pointer, byte-offset bits zero-filled below it
  always_comb begin
    fifoRdAddr = '0;
    fifoRdAddr[FIFO_AWIDTH+ADDR_NC_BITS-1 -: FIFO_AWIDTH] = rdPtr[FIFO_AWIDTH-1:0];
  end

  // Output-stage next state and which register captures what this cycle
  always_comb begin
    nextState  = state;
    loadMain   = 1'b0;
    loadSkid   = 1'b0;
    skidToMain = 1'b0;
    case (state)
      EMPTY: begin
        if (load) begin
          nextState = ONE;
          loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (pop && load) begin
          loadMain = 1'b1;
        end else if (pop) begin
          nextState = EMPTY;
        end else if (load) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          skidToMain = 1'b1;
          if (load) begin
            loadSkid = 1'b1;
          end else begin
            nextState = ONE;
          end
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  // State, pointer and data registers; flush overrides any load in the same cycle
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= EMPTY;
      rdPtr    <= '0;
      mainData <= '0;
      skidData <= '0;
      ovfErr   <= 1'b0;
    end else begin
      if (ramCnt > DEPTH) begin
        ovfErr <= 1'b1;
      end
      if (flush) begin
        state <= EMPTY;
        rdPtr <= wrPtr;
      end else begin
        state <= nextState;
        if (load) begin
          rdPtr <= rdPtr + 1'b1;
        end
        if (loadMain) begin
          mainData <= fifoRdData;
        end else if (skidToMain) begin
          mainData <= skidData;
        end
        if (loadSkid) begin
          skidData <= fifoRdData;
        end
      end
    end
  end

endmodule
